// File: rtl/waveform_pkg.sv
// Shared types and helpers for the triggered waveform capture buffer.
package waveform_pkg;

  localparam int unsigned DEFAULT_DATA_W = 14;
  localparam int unsigned DEFAULT_DEPTH  = 1000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PREFILL = 3'd1,
    ARMED   = 3'd2,
    CAPTURE = 3'd3,
    READOUT = 3'd4
  } state_t;

  // Increment with wrap at an arbitrary (non power-of-2) depth.
  function automatic int unsigned addr_wrap(input int unsigned a, input int unsigned depth);
    return (a + 32'd1 == depth) ? 32'd0 : a + 32'd1;
  endfunction

endpackage

// File: rtl/wave_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module wave_ram
  import waveform_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/waveform_capture_buffer.sv
// Triggered waveform recorder with pre-trigger history and valid/ready readout.
// Optional macro TRIG_TIMESTAMP_EN adds a trig_time output latched on each accepted trigger.
module waveform_capture_buffer
  import waveform_pkg::*;
#(
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  parameter int unsigned PRE_TRIG   = 100,
  parameter int unsigned CNT_W      = 16,
  parameter bit          AUTO_REARM = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] signal,
  input  logic              trigger_in,
  input  logic              arm,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [CNT_W-1:0]  waveNumber,
  output logic              busy
`ifdef TRIG_TIMESTAMP_EN
  ,
  output logic [31:0]       trig_time
`endif
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PC_W   = ADDR_W + 1;
  localparam int unsigned POST_N = DEPTH - PRE_TRIG;

  state_t r_state, w_next;

  logic              r_trig_q;
  logic [ADDR_W-1:0] r_wptr, r_start, r_rd_addr;
  logic [PC_W-1:0]   r_pre_cnt, r_post_cnt, r_rd_cnt;
  logic [CNT_W-1:0]  r_wave_num;
  logic              r_busy;

  logic              r_rd_vld, r_rd_last;
  logic              r_skid_vld, r_skid_last;
  logic [DATA_W-1:0] r_skid_data;
  logic              r_out_valid, r_out_last;
  logic [DATA_W-1:0] r_out_data;

  logic              w_trig_edge, w_prefill_done, w_cap_write, w_cap_done;
  logic              w_we, w_issue, w_accept, w_last_acc;
  logic [PC_W-1:0]   w_pre_inc, w_post_inc, w_wptr_ext;
  logic [ADDR_W-1:0] w_start;
  logic [1:0]        w_occ;
  logic [DATA_W-1:0] w_ram_rdata;

  assign w_trig_edge    = trigger_in && !r_trig_q;
  assign w_pre_inc      = r_pre_cnt + PC_W'(1);
  assign w_post_inc     = r_post_cnt + PC_W'(1);
  assign w_prefill_done = (w_pre_inc >= PC_W'(PRE_TRIG));
  assign w_cap_write    = (r_post_cnt < PC_W'(POST_N));
  assign w_cap_done     = (w_post_inc >= PC_W'(POST_N));
  assign w_accept       = r_out_valid && out_ready;
  assign w_last_acc     = w_accept && r_out_last;
  assign w_occ          = {1'b0, r_rd_vld} + {1'b0, r_out_valid} + {1'b0, r_skid_vld};

  // Record start: PRE_TRIG slots behind the trigger sample, modulo DEPTH.
  assign w_wptr_ext = PC_W'(r_wptr);
  assign w_start    = ADDR_W'((w_wptr_ext >= PC_W'(PRE_TRIG))
                              ? w_wptr_ext - PC_W'(PRE_TRIG)
                              : w_wptr_ext + PC_W'(DEPTH) - PC_W'(PRE_TRIG));

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (arm || AUTO_REARM) w_next = PREFILL;
      PREFILL: if (w_prefill_done)    w_next = ARMED;
      ARMED:   if (w_trig_edge)       w_next = CAPTURE;
      CAPTURE: if (w_cap_done)        w_next = READOUT;
      READOUT: if (w_last_acc)        w_next = IDLE;
      default:                        w_next = IDLE;
    endcase
  end

  // Reads are issued only while the read pipe plus skid can absorb the result.
  always_comb begin
    w_we    = 1'b0;
    w_issue = 1'b0;
    case (r_state)
      PREFILL, ARMED: w_we = 1'b1;
      CAPTURE:        w_we = w_cap_write;
      READOUT:        w_issue = (r_rd_cnt < PC_W'(DEPTH)) && ((w_occ < 2'd2) || w_accept);
      default:        ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_trig_q   <= 1'b0;
      r_wptr     <= '0;
      r_start    <= '0;
      r_pre_cnt  <= '0;
      r_post_cnt <= '0;
      r_rd_addr  <= '0;
      r_rd_cnt   <= '0;
      r_wave_num <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_trig_q <= trigger_in;
      r_busy   <= (w_next != IDLE);
      if (w_we) r_wptr <= ADDR_W'(addr_wrap(32'(r_wptr), DEPTH));
      if (r_state == PREFILL) r_pre_cnt <= w_pre_inc;
      else                    r_pre_cnt <= '0;
      if (r_state == ARMED && w_trig_edge) begin
        r_start    <= w_start;
        r_post_cnt <= PC_W'(1);
      end else if (r_state == CAPTURE && w_cap_write) begin
        r_post_cnt <= w_post_inc;
      end
      if (r_state == CAPTURE && w_cap_done) begin
        r_rd_addr  <= r_start;
        r_rd_cnt   <= '0;
        r_wave_num <= r_wave_num + CNT_W'(1);
      end else if (w_issue) begin
        r_rd_addr <= ADDR_W'(addr_wrap(32'(r_rd_addr), DEPTH));
        r_rd_cnt  <= r_rd_cnt + PC_W'(1);
      end
    end
  end

  // Output register backed by a one-deep skid for the RAM read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_vld    <= 1'b0;
      r_rd_last   <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_skid_last <= 1'b0;
      r_skid_data <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_rd_vld <= w_issue;
      if (w_issue) r_rd_last <= (r_rd_cnt == PC_W'(DEPTH - 1));
      if (w_accept || !r_out_valid) begin
        if (r_skid_vld) begin
          r_out_valid <= 1'b1;
          r_out_data  <= r_skid_data;
          r_out_last  <= r_skid_last;
          r_skid_vld  <= r_rd_vld;
          r_skid_data <= w_ram_rdata;
          r_skid_last <= r_rd_last;
        end else if (r_rd_vld) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_ram_rdata;
          r_out_last  <= r_rd_last;
        end else begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end
      end else if (r_rd_vld) begin
        r_skid_vld  <= 1'b1;
        r_skid_data <= w_ram_rdata;
        r_skid_last <= r_rd_last;
      end
    end
  end

  wave_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (signal),
    .i_re    (w_issue),
    .i_raddr (r_rd_addr),
    .o_rdata (w_ram_rdata)
  );

`ifdef TRIG_TIMESTAMP_EN
  logic [31:0] r_cycle, r_trig_time;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle     <= '0;
      r_trig_time <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (r_state == ARMED && w_trig_edge) r_trig_time <= r_cycle;
    end
  end

  assign trig_time = r_trig_time;
`endif

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign out_last   = r_out_last;
  assign waveNumber = r_wave_num;
  assign busy       = r_busy;

endmodule

// File: tb/tb_waveform_capture_buffer.sv
// Bench: two instances (manual re-arm with PRE_TRIG=4, auto re-arm with PRE_TRIG=0), ramp input.
module tb_waveform_capture_buffer;

  localparam int unsigned DW  = 14;
  localparam int unsigned DEP = 16;
  localparam int unsigned CW  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_a, reset_b, arm_a, arm_b, trig_a, trig_b, ready_a, ready_b;
  logic [DW-1:0] signal;
  logic [DW-1:0] data_a, data_b;
  logic          valid_a, valid_b, last_a, last_b, busy_a, busy_b;
  logic [CW-1:0] wn_a, wn_b;
`ifdef TRIG_TIMESTAMP_EN
  logic [31:0]   tt_a, tt_b;
`endif

  waveform_capture_buffer #(
    .DATA_W(DW), .DEPTH(DEP), .PRE_TRIG(4), .CNT_W(CW), .AUTO_REARM(1'b0)
  ) u_a (
    .clk(clk), .reset(reset_a), .signal(signal), .trigger_in(trig_a), .arm(arm_a),
    .out_data(data_a), .out_valid(valid_a), .out_ready(ready_a), .out_last(last_a),
    .waveNumber(wn_a), .busy(busy_a)
`ifdef TRIG_TIMESTAMP_EN
    , .trig_time(tt_a)
`endif
  );

  waveform_capture_buffer #(
    .DATA_W(DW), .DEPTH(DEP), .PRE_TRIG(0), .CNT_W(CW), .AUTO_REARM(1'b1)
  ) u_b (
    .clk(clk), .reset(reset_b), .signal(signal), .trigger_in(trig_b), .arm(arm_b),
    .out_data(data_b), .out_valid(valid_b), .out_ready(ready_b), .out_last(last_b),
    .waveNumber(wn_b), .busy(busy_b)
`ifdef TRIG_TIMESTAMP_EN
    , .trig_time(tt_b)
`endif
  );

  // Expected stream: filled from the trigger value, consumed by accepted beats.
  int exp_q[$];
  int errors = 0;
  int checks = 0;
  int rec_beats = 0;
  int rec_first = -1;
  int rec_last  = -1;
  bit sel = 1'b0;
  bit cmp_en = 1'b0;
  bit p_stall = 1'b0;
  bit p_lastacc = 1'b0;
  logic [DW-1:0] p_data = '0;
  logic cv, cr, cl, co;
  logic [DW-1:0] cd;
  int ce;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    signal = signal + 1'b1;
  endtask

  task automatic wait_sig(input int v);
    for (int i = 0; i < 2000 && signal != DW'(v); i++) step();
  endtask

  task automatic push_rec(input int trig_val, input int pre);
    for (int k = 0; k < int'(DEP); k++) exp_q.push_back(trig_val - pre + k);
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
    check(name, exp_q.size(), 0);
  endtask

  // Per-cycle stream checker against the expected queue and handshake rules.
  always @(negedge clk) begin
    if (cmp_en) begin
      cv = sel ? valid_b : valid_a;
      cr = sel ? ready_b : ready_a;
      cl = sel ? last_b  : last_a;
      cd = sel ? data_b  : data_a;
      co = sel ? valid_a : valid_b;
      check("other_dut_valid", int'(co), 0);
      if (p_stall) begin
        check("stall_valid", int'(cv), 1);
        check("stall_data", int'(cd), int'(p_data));
      end
      if (p_lastacc) check("valid_after_last", int'(cv), 0);
      if (cv && cr) begin
        check("beat_pending", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          ce = exp_q.pop_front();
          check("beat_data", int'(cd), ce);
          check("beat_last", int'(cl), int'(exp_q.size() == 0));
        end
        if (rec_beats == 0) rec_first = int'(cd);
        rec_beats++;
        if (cl) begin
          rec_last  = int'(cd);
          rec_beats = 0;
        end
      end
      p_stall   = cv && !cr;
      p_data    = cd;
      p_lastacc = cv && cr && cl;
    end
  end

  initial begin
    signal = '0;
    reset_a = 1'b1; reset_b = 1'b1;
    arm_a = 1'b0; arm_b = 1'b0;
    trig_a = 1'b0; trig_b = 1'b0;
    ready_a = 1'b1; ready_b = 1'b1;
    repeat (3) step();

    check("rst_valid_a", int'(valid_a), 0);
    check("rst_last_a", int'(last_a), 0);
    check("rst_data_a", int'(data_a), 0);
    check("rst_wave_a", int'(wn_a), 0);
    check("rst_busy_a", int'(busy_a), 0);
    check("rst_busy_b", int'(busy_b), 0);
    check("rst_valid_b", int'(valid_b), 0);
    reset_a = 1'b0;
    cmp_en  = 1'b1;
    repeat (5) step();
    check("idle_waits_arm", int'(busy_a), 0);

    // Arm, then a trigger pulse inside PREFILL that must be ignored.
    wait_sig(40);
    arm_a = 1'b1; step(); arm_a = 1'b0;
    trig_a = 1'b1; step(); trig_a = 1'b0;
    check("busy_prefill", int'(busy_a), 1);

    // Ramp capture: trigger at 100 gives 96..111.
    wait_sig(100);
    trig_a = 1'b1; push_rec(100, 4);
    repeat (3) step();
    trig_a = 1'b0;
    drain("t1_drain", 100);
    check("t1_first", rec_first, 96);
    check("t1_last", rec_last, 111);
    check("t1_wave", int'(wn_a), 1);
    repeat (2) step();
    check("t1_idle_busy", int'(busy_a), 0);

    // Manual re-arm: a trigger while IDLE is ignored.
    wait_sig(170);
    trig_a = 1'b1; step(); trig_a = 1'b0;
    repeat (30) step();
    check("t4_no_idle_trig", int'(wn_a), 1);

    // Arm again; readout with random backpressure.
    wait_sig(220);
    arm_a = 1'b1; step(); arm_a = 1'b0;
    wait_sig(240);
    trig_a = 1'b1; push_rec(240, 4); step(); trig_a = 1'b0;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      ready_a = 1'($urandom_range(0, 1));
      step();
    end
    ready_a = 1'b1;
    check("t3_drain", exp_q.size(), 0);
    check("t3_first", rec_first, 236);
    check("t3_last", rec_last, 251);
    check("t3_wave", int'(wn_a), 2);

    // Reset in the middle of a readout.
    wait_sig(350);
    arm_a = 1'b1; step(); arm_a = 1'b0;
    wait_sig(370);
    trig_a = 1'b1; push_rec(370, 4); step(); trig_a = 1'b0;
    for (int i = 0; i < 100 && rec_beats < 5; i++) step();
    check("t5_reached_5", int'(rec_beats >= 5), 1);
    reset_a = 1'b1;
    step();
    exp_q.delete();
    rec_beats = 0;
    check("t5_valid", int'(valid_a), 0);
    check("t5_busy", int'(busy_a), 0);
    check("t5_wave", int'(wn_a), 0);
    reset_a = 1'b0;
    wait_sig(450);
    arm_a = 1'b1; step(); arm_a = 1'b0;
    wait_sig(470);
    trig_a = 1'b1; push_rec(470, 4); step(); trig_a = 1'b0;
    drain("t5b_drain", 100);
    check("t5b_first", rec_first, 466);
    check("t5b_last", rec_last, 481);
    check("t5b_wave", int'(wn_a), 1);

    // Auto re-arm, PRE_TRIG=0, trigger level held high across re-arm.
    wait_sig(520);
    sel = 1'b1;
    reset_b = 1'b0;
    wait_sig(550);
    trig_b = 1'b1; push_rec(550, 0);
    wait_sig(610);
    drain("t2_drain", 1);
    check("t2_wave", int'(wn_b), 1);
    check("t2_rearmed", int'(busy_b), 1);
    check("t6_first", rec_first, 550);
    check("t6_last", rec_last, 565);
    trig_b = 1'b0;
    wait_sig(650);
    trig_b = 1'b1; push_rec(650, 0); step(); trig_b = 1'b0;
    drain("t6b_drain", 100);
    check("t6b_first", rec_first, 650);
    check("t6b_last", rec_last, 665);
    check("t6b_wave", int'(wn_b), 2);

    repeat (5) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
